// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-ported unified memory shared by instruction fetch (I)
// and the data path (D). Each access is issued with one mem_en strobe. The
// arbiter then waits a fixed MEM_LAT cycles, captures the read data into the
// owner's rdata register, and pulses the owner's done for one cycle.
//
// D normally wins over I, because the data access belongs to the older
// instruction. After MAX_D_STREAK consecutive D grants with I waiting, I is
// forced through so that fetch cannot starve.
//
// Ports:
//   clk, reset                   clock; asynchronous active-low reset
//   i_req, i_addr                fetch request, held until i_done
//   i_rdata, i_done              fetch data and one-cycle completion pulse
//   d_req, d_we, d_addr, d_wdata data request (load/store), held until d_done
//   d_rdata, d_done              load data and one-cycle completion pulse
//   mem_en, mem_we               one-cycle access strobe and write enable
//   mem_addr, mem_wdata          held for the whole access
//   mem_rdata                    memory read data
//   busy                         high whenever an access is in progress
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MEM_LAT      = 2,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CntW    = $clog2(MEM_LAT + 1);
  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic                owner_d_q, owner_d_d;   // 1: D owns the access, 0: I
  logic                store_q, store_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic                busy_q;
  logic                grant_i, grant_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    owner_d_d   = owner_d_q;
    store_d     = store_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        grant_i = i_req && (!d_req || (streak_q == StreakW'(MAX_D_STREAK)));
        grant_d = d_req && !grant_i;
        if (!i_req) begin
          streak_d = '0;
        end
        if (grant_i) begin
          owner_d_d   = 1'b0;
          store_d     = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
        if (grant_d) begin
          owner_d_d   = 1'b1;
          store_d     = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (i_req && (streak_q != StreakW'(MAX_D_STREAK))) begin
            streak_d = streak_q + StreakW'(1);
          end
        end
        if (grant_i || grant_d) begin
          cnt_d    = CntW'(MEM_LAT);
          mem_en_d = 1'b1;
          mem_we_d = grant_d && d_we;
          state_d  = StAcc;
        end
      end
      StAcc: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
          if (owner_d_q) begin
            d_done_d = 1'b1;
            if (!store_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end
      end
      StResp: begin
        // Requests are ignored here so a request still held during its own
        // done cycle is not issued a second time.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      streak_q    <= '0;
      owner_d_q   <= 1'b0;
      store_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      owner_d_q   <= owner_d_d;
      store_q     <= store_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_done    = i_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
